// File: rtl/restoring_divider.sv
// Sequential 8-bit restoring divider: one SHIFT/TRIAL cycle pair per quotient bit.
// Define DIV_SIGNED_EN for two's-complement operands (adds PRE/POST magnitude/sign states).
module restoring_divider (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Run,
   input  logic       LoadQ_ClearA,
   input  logic [7:0] Switches,
   output logic [7:0] Aval,
   output logic [7:0] Qval,
   output logic       Done,
   output logic       DivZero
);

`ifdef DIV_SIGNED_EN
   typedef enum logic [2:0] {StIdle, StShift, StTrial, StHold, StPre, StPost} state_e;
`else
   typedef enum logic [1:0] {StIdle, StShift, StTrial, StHold} state_e;
`endif

   state_e state_q, state_d;

   logic [8:0] a_q, a_d;
   logic [7:0] q_q, q_d;
   logic [7:0] d_q, d_d;
   logic [2:0] cnt_q, cnt_d;
   logic       done_q, done_d;
   logic       div_zero_q, div_zero_d;
   logic [8:0] diff;
   logic       start;
   logic       start_zero;
   logic       last_bit;

`ifdef DIV_SIGNED_EN
   logic sq_q, sq_d;
   logic sr_q, sr_d;
`endif

   assign start      = (state_q == StIdle) && !LoadQ_ClearA && Run;
   assign start_zero = start && (Switches == 8'd0);
   assign last_bit   = (cnt_q == 3'd7);
   assign diff       = a_q - {1'b0, d_q};

   // State register
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (start_zero) begin
               state_d = StHold;
            end else if (start) begin
`ifdef DIV_SIGNED_EN
               state_d = StPre;
`else
               state_d = StShift;
`endif
            end
         end
         StShift: state_d = StTrial;
         StTrial: begin
            if (last_bit) begin
`ifdef DIV_SIGNED_EN
               state_d = StPost;
`else
               state_d = StHold;
`endif
            end else begin
               state_d = StShift;
            end
         end
         StHold: begin
            if (!Run) begin
               state_d = StIdle;
            end
         end
`ifdef DIV_SIGNED_EN
         StPre:  state_d = StShift;
         StPost: state_d = StHold;
`endif
         default: state_d = StIdle;
      endcase
   end

   // Datapath next-state
   always_comb begin
      a_d        = a_q;
      q_d        = q_q;
      d_d        = d_q;
      cnt_d      = cnt_q;
      done_d     = done_q;
      div_zero_d = div_zero_q;
`ifdef DIV_SIGNED_EN
      sq_d       = sq_q;
      sr_d       = sr_q;
`endif
      case (state_q)
         StIdle: begin
            if (LoadQ_ClearA) begin
               q_d        = Switches;
               a_d        = 9'd0;
               done_d     = 1'b0;
               div_zero_d = 1'b0;
            end else if (start_zero) begin
               // Divide by zero: dividend moves to A, quotient saturates
               a_d        = {1'b0, q_q};
               q_d        = 8'hFF;
               div_zero_d = 1'b1;
               done_d     = 1'b1;
            end else if (start) begin
               d_d        = Switches;
               cnt_d      = 3'd0;
               done_d     = 1'b0;
               div_zero_d = 1'b0;
            end
         end
         StShift: begin
            {a_d, q_d} = {a_q[7:0], q_q, 1'b0};
         end
         StTrial: begin
            // Restore by simply not writing A when the trial subtraction underflows
            if (a_q >= {1'b0, d_q}) begin
               a_d    = diff;
               q_d[0] = 1'b1;
            end
            if (last_bit) begin
`ifndef DIV_SIGNED_EN
               done_d = 1'b1;
`endif
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
`ifdef DIV_SIGNED_EN
         StPre: begin
            sq_d = q_q[7] ^ d_q[7];
            sr_d = q_q[7];
            q_d  = q_q[7] ? (~q_q + 8'd1) : q_q;
            d_d  = d_q[7] ? (~d_q + 8'd1) : d_q;
         end
         StPost: begin
            q_d    = sq_q ? (~q_q + 8'd1) : q_q;
            a_d    = sr_q ? (~a_q + 9'd1) : a_q;
            done_d = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         a_q        <= 9'd0;
         q_q        <= 8'd0;
         d_q        <= 8'd0;
         cnt_q      <= 3'd0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
`ifdef DIV_SIGNED_EN
         sq_q       <= 1'b0;
         sr_q       <= 1'b0;
`endif
      end else begin
         a_q        <= a_d;
         q_q        <= q_d;
         d_q        <= d_d;
         cnt_q      <= cnt_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
`ifdef DIV_SIGNED_EN
         sq_q       <= sq_d;
         sr_q       <= sr_d;
`endif
      end
   end

   // Outputs
   always_comb begin
      Aval    = a_q[7:0];
      Qval    = q_q;
      Done    = done_q;
      DivZero = div_zero_q;
   end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: vector table, corner sequences, random vs. model.
// Honours DIV_SIGNED_EN for expected values and latency.
module tb_restoring_divider;

   logic       Clk;
   logic       Reset;
   logic       Run;
   logic       LoadQ_ClearA;
   logic [7:0] Switches;
   logic [7:0] Aval;
   logic [7:0] Qval;
   logic       Done;
   logic       DivZero;

   int n_checks;
   int n_fail;

`ifdef DIV_SIGNED_EN
   localparam int Latency = 18;
`else
   localparam int Latency = 16;
`endif

   restoring_divider dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .Run          (Run),
      .LoadQ_ClearA (LoadQ_ClearA),
      .Switches     (Switches),
      .Aval         (Aval),
      .Qval         (Qval),
      .Done         (Done),
      .DivZero      (DivZero)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic [7:0] dividend;
      logic [7:0] divisor;
      logic [7:0] exp_q;
      logic [7:0] exp_a;
      logic       exp_dz;
   } vec_t;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // Reference: plain integer division from the arithmetic rules
   function automatic void model(input logic [7:0] n, input logic [7:0] d,
                                 output logic [7:0] q, output logic [7:0] r,
                                 output logic dz);
      int ni, di, qi, ri;
      ni = 0; di = 0; qi = 0; ri = 0;
      if (d == 8'd0) begin
         q  = 8'hFF;
         r  = n;
         dz = 1'b1;
      end else begin
`ifdef DIV_SIGNED_EN
         ni = int'($signed(n));
         di = int'($signed(d));
`else
         ni = int'(n);
         di = int'(d);
`endif
         qi = ni / di;
         ri = ni % di;
         q  = qi[7:0];
         r  = ri[7:0];
         dz = 1'b0;
      end
   endfunction

   task automatic load(input logic [7:0] n);
      Switches     = n;
      LoadQ_ClearA = 1'b1;
      step();
      LoadQ_ClearA = 1'b0;
   endtask

   // Starts with Run held high; leaves Run high (caller releases)
   task automatic run_op(input logic [7:0] d, input logic [7:0] eq, input logic [7:0] ea,
                         input logic edz, input string tag);
      int cyc;
      Switches = d;
      Run      = 1'b1;
      step();
      cyc = 0;
      while (!Done && cyc < 40) begin
         step();
         cyc++;
      end
      check({tag, " latency"}, cyc, edz ? 0 : Latency);
      check({tag, " Qval"}, int'(Qval), int'(eq));
      check({tag, " Aval"}, int'(Aval), int'(ea));
      check({tag, " Done"}, int'(Done), 1);
      check({tag, " DivZero"}, int'(DivZero), int'(edz));
   endtask

   task automatic release_run(input logic [7:0] eq, input string tag);
      Run = 1'b0;
      step();
      check({tag, " Done after release"}, int'(Done), 1);
      check({tag, " Qval after release"}, int'(Qval), int'(eq));
   endtask

   task automatic do_div(input logic [7:0] n, input logic [7:0] d, input string tag);
      logic [7:0] eq, ea;
      logic       edz;
      model(n, d, eq, ea, edz);
      load(n);
      run_op(d, eq, ea, edz, tag);
      release_run(eq, tag);
   endtask

   vec_t vecs[$];

   initial begin
      logic [7:0] eq, ea, n, d;
      logic       edz;
      n_checks = 0;
      n_fail   = 0;

`ifdef DIV_SIGNED_EN
      vecs.push_back('{8'h9C, 8'd7,  8'hF2, 8'hFE, 1'b0});
      vecs.push_back('{8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0});
      vecs.push_back('{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0});
      vecs.push_back('{8'd5,  8'd0,  8'hFF, 8'h05, 1'b1});
      vecs.push_back('{8'h7F, 8'd2,  8'h3F, 8'h01, 1'b0});
      vecs.push_back('{8'h81, 8'h80, 8'h00, 8'h81, 1'b0});
`else
      vecs.push_back('{8'd100, 8'd7,   8'h0E, 8'h02, 1'b0});
      vecs.push_back('{8'd255, 8'd1,   8'hFF, 8'h00, 1'b0});
      vecs.push_back('{8'd3,   8'd200, 8'h00, 8'h03, 1'b0});
      vecs.push_back('{8'd5,   8'd0,   8'hFF, 8'h05, 1'b1});
      vecs.push_back('{8'd0,   8'd9,   8'h00, 8'h00, 1'b0});
      vecs.push_back('{8'd255, 8'd255, 8'h01, 8'h00, 1'b0});
      vecs.push_back('{8'd128, 8'd3,   8'h2A, 8'h02, 1'b0});
`endif

      Reset        = 1'b1;
      Run          = 1'b0;
      LoadQ_ClearA = 1'b0;
      Switches     = 8'd0;
      step();
      step();
      Reset = 1'b0;
      check("reset Aval", int'(Aval), 0);
      check("reset Qval", int'(Qval), 0);
      check("reset Done", int'(Done), 0);
      check("reset DivZero", int'(DivZero), 0);

      for (int i = 0; i < vecs.size(); i++) begin
         load(vecs[i].dividend);
         check($sformatf("vec%0d load Qval", i), int'(Qval), int'(vecs[i].dividend));
         check($sformatf("vec%0d load Aval", i), int'(Aval), 0);
         check($sformatf("vec%0d load Done", i), int'(Done), 0);
         run_op(vecs[i].divisor, vecs[i].exp_q, vecs[i].exp_a, vecs[i].exp_dz,
                $sformatf("vec%0d", i));
         release_run(vecs[i].exp_q, $sformatf("vec%0d", i));
      end

      // Run held high after completion must not restart; then chained division
      model(8'd255, 8'd1, eq, ea, edz);
      load(8'd255);
      run_op(8'd1, eq, ea, edz, "hold");
      Switches = 8'd3;
      for (int i = 0; i < 40; i++) begin
         step();
         check("hold Qval stable", int'(Qval), int'(eq));
         check("hold Aval stable", int'(Aval), int'(ea));
         check("hold Done stable", int'(Done), 1);
      end
      release_run(eq, "hold");
      n = eq;
      model(n, 8'd2, eq, ea, edz);
      run_op(8'd2, eq, ea, edz, "chained");
      release_run(eq, "chained");

      // LoadQ_ClearA has priority over Run in IDLE
      Switches     = 8'h3C;
      LoadQ_ClearA = 1'b1;
      Run          = 1'b1;
      step();
      check("prio Qval", int'(Qval), 8'h3C);
      check("prio Aval", int'(Aval), 0);
      check("prio Done", int'(Done), 0);
      LoadQ_ClearA = 1'b0;
      Run          = 1'b0;
      step();

      // LoadQ_ClearA ignored mid-operation
      model(8'd100, 8'd7, eq, ea, edz);
      load(8'd100);
      Switches = 8'd7;
      Run      = 1'b1;
      step();
      step();
      step();
      Switches     = 8'h55;
      LoadQ_ClearA = 1'b1;
      step();
      LoadQ_ClearA = 1'b0;
      begin
         int cyc;
         cyc = 3;
         while (!Done && cyc < 40) begin
            step();
            cyc++;
         end
         check("midload latency", cyc, Latency);
      end
      check("midload Qval", int'(Qval), int'(eq));
      check("midload Aval", int'(Aval), int'(ea));
      release_run(eq, "midload");

      // Reset during an operation
      load(8'd100);
      Switches = 8'd7;
      Run      = 1'b1;
      step();
      repeat (5) step();
      Reset = 1'b1;
      Run   = 1'b0;
      step();
      Reset = 1'b0;
      check("midreset Aval", int'(Aval), 0);
      check("midreset Qval", int'(Qval), 0);
      check("midreset Done", int'(Done), 0);
      check("midreset DivZero", int'(DivZero), 0);
      repeat (3) step();
      check("midreset idle Done", int'(Done), 0);
      do_div(8'd100, 8'd7, "after reset");

      // Random operands against the model
      for (int i = 0; i < 40; i++) begin
         n = 8'($urandom);
         d = (i % 8 == 0) ? 8'd0 : 8'($urandom);
         do_div(n, d, $sformatf("rand%0d %0d/%0d", i, n, d));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/restoring_divider.md
# restoring_divider

Sequential 8-bit restoring divider, the division counterpart of the lab's shift-add multiplier. It contains its own control FSM and datapath. The dividend is loaded from the switches by a load button, and the divisor is sampled from the switches when Run is pressed. The block then produces an 8-bit quotient and remainder in one shift/trial cycle pair per bit. Results drive the hex displays at the top level.

## Interface
- No parameters; width fixed at 8.
- Clk  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- Run  input  1  level, debounced; start request.
- LoadQ_ClearA  input  1  level, debounced; loads dividend, clears remainder.
- Switches  input  8  operand source (dividend on load, divisor on start).
- Aval  output  8  remainder register A[7:0].
- Qval  output  8  quotient/dividend register Q.
- Done  output  1  result valid.
- DivZero  output  1  last operation had divisor 0.

## Operation
- Registers: A (9-bit internal; Aval = A[7:0]), Q (8-bit), D (8-bit divisor), cnt (3-bit), Done, DivZero.
- States: IDLE, SHIFT, TRIAL, HOLD, plus PRE and POST when DIV_SIGNED_EN is defined.
- IDLE, LoadQ_ClearA=1:
  - Q<=Switches, A<=0, Done<=0, DivZero<=0.
  - Priority over Run in the same cycle; Run is ignored that cycle.
- IDLE, Run=1, LoadQ_ClearA=0, Switches!=0:
  - D<=Switches, cnt<=0, Done<=0, DivZero<=0.
  - Next state SHIFT (or PRE when signed).
- IDLE, Run=1, Switches==0 (divide by zero):
  - A<={1'b0,Q}, Q<=8'hFF, DivZero<=1, Done<=1.
  - Next state HOLD; no iterations run.
- SHIFT: {A,Q} <= {A,Q}<<1 (Q[0]<=0). Next state TRIAL.
- TRIAL:
  - diff = A - {1'b0,D} in 9 bits.
  - If A >= D: A<=diff, Q[0]<=1. Otherwise A unchanged (restore by not writing).
  - If cnt==7: go to HOLD (or POST), Done<=1 on entry to HOLD. Otherwise cnt<=cnt+1, go to SHIFT.
- HOLD: registers frozen; stay while Run=1. When Run=0, go to IDLE; Done stays 1.
- After HOLD, Q holds the quotient. A new Run in IDLE divides that quotient by the new divisor (chained division).
- Invariant: A < 2*D at every SHIFT→TRIAL boundary, so 9 bits never overflow; final remainder < D fits Aval.

## Timing
- Reset (any state, including mid-operation): state IDLE; A, Q, D, cnt = 0; Aval=0, Qval=0, Done=0, DivZero=0.
- Let edge 0 be the edge that samples Run=1 in IDLE.
- Unsigned latency: 16 edges (8 × SHIFT+TRIAL). Done=1 and results valid after edge 16.
- Signed latency: 18 edges (PRE + 16 + POST).
- Divide-by-zero latency: Done=1 after edge 0.
- Aval and Qval change every cycle during iteration; they are meaningful only when Done=1.
- Run held high across HOLD never restarts; a release (≥1 cycle low) is required.
- LoadQ_ClearA is ignored in every state except IDLE.

## Configuration
- Macro DIV_SIGNED_EN.
- Undefined: operands and results unsigned.
- Defined: two's-complement operands.
  - PRE (1 cycle): records sq = Q[7]^D[7] and sr = Q[7]; replaces Q and D with their magnitudes (8-bit, so |−128| = 0x80 unsigned).
  - POST (1 cycle): Q <= sq ? −Q : Q, A <= sr ? −A : A.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - −128 / −1 yields Q=0x80, A=0x00 (wraps, no flag).
  - Divide by zero behaves as in the unsigned case.

## Test plan
- Load 100, Run with 7 → after 16 cycles Qval=14 (0x0E), Aval=2, Done=1, DivZero=0.
- Load 255, Run with 1 → Qval=0xFF, Aval=0. Load 3, Run with 200 → Qval=0, Aval=3.
- Load 5, Run with 0 → after 1 cycle Qval=0xFF, Aval=0x05, DivZero=1, Done=1.
- Run held high 40 cycles after completion → no restart, outputs stable. Release, then Run with 2 → Qval=0x7F (chained 255/2) when started from a 255 quotient.
- Reset asserted at cycle 5 of an operation → next cycle all outputs 0, state IDLE. Fresh load 100, Run with 7 → correct result.
- DIV_SIGNED_EN: −100/7 → Qval=0xF2 (−14), Aval=0xFE (−2) at 18 cycles. 100/−7 → 0xF2, 0x02. −128/−1 → 0x80, 0x00.
